// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per producer, up to two rotating-priority grants per
// cycle, winners driven on two registered CDB lanes.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_val,
    output logic                      cdb1_ok,
    output logic [TAG_W-1:0]          cdb1_en,
    output logic [DATA_W-1:0]         cdb1_val,
    output logic                      cdb2_ok,
    output logic [TAG_W-1:0]          cdb2_en,
    output logic [DATA_W-1:0]         cdb2_val
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] slot_v_q, slot_v_d;
    logic [TAG_W-1:0]   slot_tag_q [NUM_REQ];
    logic [TAG_W-1:0]   slot_tag_d [NUM_REQ];
    logic [DATA_W-1:0]  slot_val_q [NUM_REQ];
    logic [DATA_W-1:0]  slot_val_d [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               cdb1_ok_q, cdb1_ok_d, cdb2_ok_q, cdb2_ok_d;
    logic [TAG_W-1:0]   cdb1_en_q, cdb1_en_d, cdb2_en_q, cdb2_en_d;
    logic [DATA_W-1:0]  cdb1_val_q, cdb1_val_d, cdb2_val_q, cdb2_val_d;

    logic               g1_v, g2_v;
    logic [PTR_W-1:0]   g1_idx, g2_idx;
    logic [NUM_REQ-1:0] granted;

    // Rotating scan from rr_ptr; the first two valid slots win.
    always_comb begin
        logic [PTR_W-1:0] idx;
        g1_v    = 1'b0;
        g2_v    = 1'b0;
        g1_idx  = '0;
        g2_idx  = '0;
        granted = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (slot_v_q[idx]) begin
                if (!g1_v) begin
                    g1_v         = 1'b1;
                    g1_idx       = idx;
                    granted[idx] = 1'b1;
                end else if (!g2_v) begin
                    g2_v         = 1'b1;
                    g2_idx       = idx;
                    granted[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = (rdy && !clear && !rst) ? (~slot_v_q | granted) : '0;

    always_comb begin
        slot_v_d   = slot_v_q;
        slot_tag_d = slot_tag_q;
        slot_val_d = slot_val_q;
        rr_ptr_d   = rr_ptr_q;
        cdb1_ok_d  = cdb1_ok_q;
        cdb1_en_d  = cdb1_en_q;
        cdb1_val_d = cdb1_val_q;
        cdb2_ok_d  = cdb2_ok_q;
        cdb2_en_d  = cdb2_en_q;
        cdb2_val_d = cdb2_val_q;
        if (rst) begin
            slot_v_d   = '0;
            rr_ptr_d   = '0;
            cdb1_ok_d  = 1'b0;
            cdb1_en_d  = '0;
            cdb1_val_d = '0;
            cdb2_ok_d  = 1'b0;
            cdb2_en_d  = '0;
            cdb2_val_d = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_tag_d[i] = '0;
                slot_val_d[i] = '0;
            end
        end else if (clear) begin
            slot_v_d   = '0;
            cdb1_ok_d  = 1'b0;
            cdb1_en_d  = '0;
            cdb1_val_d = '0;
            cdb2_ok_d  = 1'b0;
            cdb2_en_d  = '0;
            cdb2_val_d = '0;
        end else if (rdy) begin
            // A granted slot may be refilled on the same edge it drains.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    slot_v_d[i]   = 1'b1;
                    slot_tag_d[i] = req_tag[i*TAG_W +: TAG_W];
                    slot_val_d[i] = req_val[i*DATA_W +: DATA_W];
                end else if (granted[i]) begin
                    slot_v_d[i] = 1'b0;
                end
            end
            cdb1_ok_d  = g1_v;
            cdb1_en_d  = g1_v ? slot_tag_q[g1_idx] : '0;
            cdb1_val_d = g1_v ? slot_val_q[g1_idx] : '0;
            cdb2_ok_d  = g2_v;
            cdb2_en_d  = g2_v ? slot_tag_q[g2_idx] : '0;
            cdb2_val_d = g2_v ? slot_val_q[g2_idx] : '0;
            if (g2_v) begin
                rr_ptr_d = PTR_W'((32'(g2_idx) + 32'd1) % NUM_REQ);
            end else if (g1_v) begin
                rr_ptr_d = PTR_W'((32'(g1_idx) + 32'd1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        slot_v_q   <= slot_v_d;
        slot_tag_q <= slot_tag_d;
        slot_val_q <= slot_val_d;
        rr_ptr_q   <= rr_ptr_d;
        cdb1_ok_q  <= cdb1_ok_d;
        cdb1_en_q  <= cdb1_en_d;
        cdb1_val_q <= cdb1_val_d;
        cdb2_ok_q  <= cdb2_ok_d;
        cdb2_en_q  <= cdb2_en_d;
        cdb2_val_q <= cdb2_val_d;
    end

    assign cdb1_ok  = cdb1_ok_q;
    assign cdb1_en  = cdb1_en_q;
    assign cdb1_val = cdb1_val_q;
    assign cdb2_ok  = cdb2_ok_q;
    assign cdb2_en  = cdb2_en_q;
    assign cdb2_val = cdb2_val_q;

endmodule
